// File: rtl/set_assoc_refill_ctrl.sv
// Miss refill writer for a 2-way set-associative cache: fetch block, pick victim, write line, track LRU.
// Optional macro CRITICAL_WORD_FIRST_EN: fetch starts at the missed word (wrap order) and forwards it early.
module set_assoc_refill_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int TAG_W   = 5,
  parameter int INDEX_W = 7,
  parameter int DATA_W  = 32,
  parameter int WORDS   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                req_valid_i,
  input  logic [ADDR_W-1:0]                   req_addr_i,
  output logic                                req_ready_o,
  input  logic                                way0_valid_i,
  input  logic                                way1_valid_i,
  input  logic                                hit_i,
  input  logic                                hit_way_i,
  input  logic [INDEX_W-1:0]                  hit_index_i,
  output logic                                mem_req_o,
  output logic [ADDR_W-1:0]                   mem_addr_o,
  input  logic                                mem_gnt_i,
  input  logic                                mem_rvalid_i,
  input  logic [DATA_W-1:0]                   mem_rdata_i,
  output logic                                wr_en_o,
  output logic                                wr_way_o,
  output logic [INDEX_W-1:0]                  wr_index_o,
  output logic [1+TAG_W+WORDS*DATA_W-1:0]     wr_line_o,
  output logic                                fwd_valid_o,
  output logic [DATA_W-1:0]                   fwd_data_o,
  output logic                                done_o,
  output logic                                err_o
);
  localparam int WOFF_W = $clog2(WORDS);
  localparam int LSB_W  = WOFF_W + 2;
  localparam int LINE_W = 1 + TAG_W + WORDS * DATA_W;
  localparam int SETS   = 1 << INDEX_W;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [WOFF_W-1:0] BEAT_LAST = WOFF_W'(WORDS - 1);
`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);
`else
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << LSB_W) - 1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_WRITE, S_DONE, S_ERR} state_t;

  state_t                          state_q, state_d;
  logic [WOFF_W-1:0]               cnt_q, cnt_d, widx_s;
  logic [TMO_W-1:0]                tmo_q, tmo_d;
  logic [TAG_W-1:0]                tag_q, tag_d;
  logic [INDEX_W-1:0]              index_q, index_d;
  logic [WOFF_W-1:0]               off_q, off_d;
  logic                            victim_q, victim_d;
  logic [WORDS-1:0][DATA_W-1:0]    data_q, data_d;
  logic [SETS-1:0]                 lru_q, lru_d, lru_hit_s;
  logic                            req_ready_q, req_ready_d, mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]               mem_addr_q, mem_addr_d;
  logic                            wr_en_q, wr_en_d, wr_way_q, wr_way_d;
  logic [INDEX_W-1:0]              wr_index_q, wr_index_d;
  logic [LINE_W-1:0]               wr_line_q, wr_line_d;
  logic                            fwd_valid_q, fwd_valid_d, done_q, done_d, err_q, err_d;
  logic [DATA_W-1:0]               fwd_data_q, fwd_data_d;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    tag_d      = tag_q;
    index_d    = index_q;
    off_d      = off_q;
    victim_d   = victim_q;
    data_d     = data_q;
    mem_addr_d = mem_addr_q;
`ifdef CRITICAL_WORD_FIRST_EN
    widx_s = off_q + cnt_q;
`else
    widx_s = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          state_d    = S_REQ;
          tmo_d      = '0;
          cnt_d      = '0;
          tag_d      = req_addr_i[ADDR_W-1 -: TAG_W];
          index_d    = req_addr_i[LSB_W +: INDEX_W];
          off_d      = req_addr_i[2 +: WOFF_W];
          mem_addr_d = req_addr_i & ADDR_MASK;
          victim_d   = !way0_valid_i ? 1'b0 :
                       !way1_valid_i ? 1'b1 : lru_q[req_addr_i[LSB_W +: INDEX_W]];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          state_d = S_FILL;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_FILL: begin
        if (mem_rvalid_i) begin
          data_d[widx_s] = mem_rdata_i;
          tmo_d          = '0;
          cnt_d          = cnt_q + 1'b1;
          state_d        = (cnt_q == BEAT_LAST) ? S_WRITE : S_FILL;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A line write to the same set overrides a coincident hit.
    lru_hit_s = lru_q;
    if (hit_i) begin
      lru_hit_s[hit_index_i] = ~hit_way_i;
    end else begin
      lru_hit_s = lru_q;
    end
    if (state_q == S_WRITE) begin
      lru_d           = lru_hit_s;
      lru_d[index_q]  = ~victim_q;
    end else begin
      lru_d = lru_hit_s;
    end

    req_ready_d = (state_d == S_IDLE);
    mem_req_d   = (state_d == S_REQ);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    wr_en_d     = (state_d == S_WRITE);
    wr_line_d   = '0;
    if (wr_en_d) begin
      wr_way_d   = victim_q;
      wr_index_d = index_q;
      wr_line_d[LINE_W-1]          = 1'b1;
      wr_line_d[LINE_W-2 -: TAG_W] = tag_q;
      for (int w = 0; w < WORDS; w++) begin
        wr_line_d[(WORDS-1-w)*DATA_W +: DATA_W] = data_d[w];
      end
    end else begin
      wr_way_d   = 1'b0;
      wr_index_d = '0;
    end
`ifdef CRITICAL_WORD_FIRST_EN
    fwd_valid_d = (state_q == S_FILL) && mem_rvalid_i && (cnt_q == '0);
    fwd_data_d  = fwd_valid_d ? mem_rdata_i : '0;
`else
    fwd_valid_d = done_d;
    fwd_data_d  = done_d ? data_q[off_q] : '0;
`endif
  end

  // State and output registers; reset discards any partial refill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      tag_q       <= '0;
      index_q     <= '0;
      off_q       <= '0;
      victim_q    <= 1'b0;
      data_q      <= '0;
      lru_q       <= '0;
      req_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_way_q    <= 1'b0;
      wr_index_q  <= '0;
      wr_line_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      tag_q       <= tag_d;
      index_q     <= index_d;
      off_q       <= off_d;
      victim_q    <= victim_d;
      data_q      <= data_d;
      lru_q       <= lru_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      wr_en_q     <= wr_en_d;
      wr_way_q    <= wr_way_d;
      wr_index_q  <= wr_index_d;
      wr_line_q   <= wr_line_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_data_q  <= fwd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign wr_en_o     = wr_en_q;
  assign wr_way_o    = wr_way_q;
  assign wr_index_o  = wr_index_q;
  assign wr_line_o   = wr_line_q;
  assign fwd_valid_o = fwd_valid_q;
  assign fwd_data_o  = fwd_data_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_set_assoc_refill_ctrl.sv
// Randomized self-checking bench for set_assoc_refill_ctrl against a transaction-level model.
module tb_set_assoc_refill_ctrl;
  logic         clk = 1'b0, rst = 1'b1;
  logic         req_valid = 1'b0, way0_v = 1'b0, way1_v = 1'b0;
  logic [15:0]  req_addr = 16'h0;
  logic         hit = 1'b0, hit_way = 1'b0;
  logic [6:0]   hit_index = 7'h0;
  logic         mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = 32'h0;
  logic         req_ready_o, mem_req_o, wr_en_o, wr_way_o, fwd_valid_o, done_o, err_o;
  logic [15:0]  mem_addr_o;
  logic [6:0]   wr_index_o;
  logic [133:0] wr_line_o;
  logic [31:0]  fwd_data_o;

  set_assoc_refill_ctrl dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_ready_o(req_ready_o), .way0_valid_i(way0_v), .way1_valid_i(way1_v),
    .hit_i(hit), .hit_way_i(hit_way), .hit_index_i(hit_index),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .wr_en_o(wr_en_o),
    .wr_way_o(wr_way_o), .wr_index_o(wr_index_o), .wr_line_o(wr_line_o),
    .fwd_valid_o(fwd_valid_o), .fwd_data_o(fwd_data_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  bit ref_lru [128];

  // Event recorder for the single-cycle output pulses.
  int wr_cnt = 0, done_cnt = 0, fwd_cnt = 0, err_cnt = 0;
  int wr_cyc = 0, done_cyc = 0, fwd_cyc = 0, err_cyc = 0;
  logic m_way = 1'b0; logic [6:0] m_idx = 7'h0; logic [133:0] m_line = '0; logic [31:0] m_fwd = '0;
  always @(negedge clk) begin
    if (wr_en_o) begin
      wr_cnt <= wr_cnt + 1; wr_cyc <= cyc; m_way <= wr_way_o; m_idx <= wr_index_o; m_line <= wr_line_o;
    end
    if (done_o) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (fwd_valid_o) begin fwd_cnt <= fwd_cnt + 1; fwd_cyc <= cyc; m_fwd <= fwd_data_o; end
    if (err_o) begin err_cnt <= err_cnt + 1; err_cyc <= cyc; end
  end

  task automatic check_eq(input string tag, input logic [133:0] act, input logic [133:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [11:0] blk, input logic [1:0] w, input bit directed);
    if (directed) return 32'h11111111 * (32'(w) + 32'd1);
    return {4'h5, blk, 6'h15, w, 8'h3C};
  endfunction

  task automatic do_hit(input logic [6:0] idx, input logic way);
    hit = 1'b1; hit_index = idx; hit_way = way;
    tick;
    hit = 1'b0;
    ref_lru[idx] = ~way;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!req_ready_o && n < 20) begin tick; n++; end
    check_eq("ready_idle", req_ready_o, 1'b1);
  endtask

  // One miss transaction; gnt_dly < 0 withholds the grant, nbeats < 4 stalls the fill.
  task automatic refill(input logic [15:0] addr, input logic v0, input logic v1, input int gnt_dly,
                        input int nbeats, input int max_gap, input bit directed, input bit junk,
                        input bit hit_wr);
    logic [1:0] off, start; logic vic; logic [15:0] exp_maddr; logic [133:0] exp_line;
    int a, last_ev, first_b, gaps, g, w0, d0, f0, e0, n;
    off = addr[3:2];
`ifdef CRITICAL_WORD_FIRST_EN
    start = off; exp_maddr = {addr[15:2], 2'b00};
`else
    start = 2'd0; exp_maddr = {addr[15:4], 4'h0};
`endif
    exp_line = {1'b1, addr[15:11], mem_word(addr[15:4], 2'd0, directed), mem_word(addr[15:4], 2'd1, directed),
                mem_word(addr[15:4], 2'd2, directed), mem_word(addr[15:4], 2'd3, directed)};
    vic = !v0 ? 1'b0 : (!v1 ? 1'b1 : ref_lru[addr[10:4]]);
    wait_ready;
    w0 = wr_cnt; d0 = done_cnt; f0 = fwd_cnt; e0 = err_cnt; gaps = 0; first_b = 0;
    req_valid = 1'b1; req_addr = addr; way0_v = v0; way1_v = v1; a = cyc;
    tick;
    req_valid = 1'b0; req_addr = 16'($urandom); way0_v = 1'($urandom); way1_v = 1'($urandom);
    check_eq("req_busy", {req_ready_o, mem_req_o}, 2'b01);
    check_eq("mem_addr", mem_addr_o, exp_maddr);
    last_ev = a;
    if (gnt_dly >= 0) begin
      for (int i = 0; i < gnt_dly; i++) begin
        mem_rvalid = junk; mem_rdata = $urandom;
        tick;
        check_eq("mem_req_hold", mem_req_o, 1'b1);
      end
      mem_rvalid = 1'b0; mem_gnt = 1'b1; last_ev = cyc;
      tick;
      mem_gnt = 1'b0;
      check_eq("mem_req_drop", mem_req_o, 1'b0);
      for (int k = 0; k < nbeats; k++) begin
        g = $urandom_range(max_gap, 0); gaps += g;
        repeat (g) tick;
        mem_rvalid = 1'b1; mem_rdata = mem_word(addr[15:4], start + 2'(k), directed);
        if (k == 0) first_b = cyc;
        last_ev = cyc;
        tick;
        mem_rvalid = 1'b0;
        if (hit_wr && k == nbeats - 1) begin
          hit = 1'b1; hit_index = addr[10:4]; hit_way = ~vic;
          tick;
          hit = 1'b0;
        end
      end
    end
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 400) begin tick; n++; end
    tick; tick;
    check_eq("mem_addr_stable", mem_addr_o, exp_maddr);
    if (gnt_dly < 0 || nbeats < 4) begin
      check_eq("err_count", 32'(err_cnt - e0), 32'd1);
      check_eq("err_cycle", 32'(err_cyc), 32'(last_ev + 256));
      check_eq("err_no_write", 32'(wr_cnt - w0 + done_cnt - d0), 32'd0);
    end else begin
      check_eq("done_count", 32'(done_cnt - d0), 32'd1);
      check_eq("wr_count", 32'(wr_cnt - w0), 32'd1);
      check_eq("err_none", 32'(err_cnt - e0), 32'd0);
      check_eq("wr_way", m_way, vic);
      check_eq("wr_index", m_idx, addr[10:4]);
      check_eq("wr_line", m_line, exp_line);
      check_eq("wr_then_done", 32'(done_cyc - wr_cyc), 32'd1);
      check_eq("latency", 32'(done_cyc - a), 32'(7 + gnt_dly + gaps));
      check_eq("fwd_count", 32'(fwd_cnt - f0), 32'd1);
      check_eq("fwd_data", m_fwd, mem_word(addr[15:4], off, directed));
`ifdef CRITICAL_WORD_FIRST_EN
      check_eq("fwd_cycle", 32'(fwd_cyc), 32'(first_b + 1));
`else
      check_eq("fwd_cycle", 32'(fwd_cyc), 32'(done_cyc));
`endif
      ref_lru[addr[10:4]] = ~vic;
    end
  endtask

  logic [6:0] idx_tab [4] = '{7'h23, 7'h05, 7'h7F, 7'h00};

  initial begin
    int w0;
    logic [15:0] ra;
    for (int i = 0; i < 128; i++) ref_lru[i] = 1'b0;
    #1;
    check_eq("rst_ctl", {req_ready_o, mem_req_o, mem_addr_o, wr_en_o, wr_way_o, wr_index_o,
                         fwd_valid_o, fwd_data_o, done_o, err_o}, '0);
    check_eq("rst_line", wr_line_o, '0);
    tick; tick;
    rst = 1'b0;
    tick;
    check_eq("rst_ready", req_ready_o, 1'b1);

    refill(16'h1A34, 1'b0, 1'b0, 0, 4, 0, 1'b1, 1'b0, 1'b0);
    refill(16'h5A34, 1'b1, 1'b1, 1, 4, 1, 1'b0, 1'b1, 1'b0);
    do_hit(7'h23, 1'b0);
    do_hit(7'h23, 1'b1);
    refill(16'h7A30, 1'b1, 1'b1, 0, 4, 0, 1'b0, 1'b0, 1'b0);
    refill(16'h0128, 1'b1, 1'b0, 2, 4, 2, 1'b0, 1'b1, 1'b0);
    refill(16'h3456, 1'b1, 1'b1, -1, 0, 0, 1'b0, 1'b0, 1'b0);
    refill(16'h3A3C, 1'b1, 1'b1, 0, 2, 1, 1'b0, 1'b0, 1'b0);
    refill(16'h1A34, 1'b0, 1'b0, 0, 4, 0, 1'b0, 1'b0, 1'b1);
    refill(16'h9A38, 1'b1, 1'b1, 0, 4, 0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a fill must discard the partial line.
    wait_ready;
    w0 = wr_cnt;
    req_valid = 1'b1; req_addr = 16'h2468; way0_v = 1'b0; way1_v = 1'b0;
    tick;
    req_valid = 1'b0; mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'(k + 7);
      tick;
    end
    mem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("midrst_ctl", {req_ready_o, mem_req_o, mem_addr_o, wr_en_o, wr_way_o, wr_index_o,
                            fwd_valid_o, fwd_data_o, done_o, err_o}, '0);
    check_eq("midrst_line", wr_line_o, '0);
    tick;
    rst = 1'b0;
    tick;
    check_eq("midrst_ready", {req_ready_o, mem_req_o}, 2'b10);
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'(k);
      tick;
    end
    mem_rvalid = 1'b0;
    repeat (8) tick;
    check_eq("midrst_no_write", 32'(wr_cnt - w0), 32'd0);
    for (int i = 0; i < 128; i++) ref_lru[i] = 1'b0;
    refill(16'h2468, 1'b1, 1'b1, 0, 4, 0, 1'b0, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      ra = {5'($urandom), idx_tab[$urandom_range(3, 0)], 2'($urandom), 2'b00};
      if ($urandom_range(2, 0) == 0) do_hit(idx_tab[$urandom_range(3, 0)], 1'($urandom));
      refill(ra, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, $urandom_range(3, 0), 4,
             2, 1'b0, 1'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end
endmodule
